pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_ctrl_pkg.sv | 21 ++
 rtl/pwm_step_timer.sv | 40 ++++
 rtl/pwm_fade_ctrl.sv | 151 +++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg -- shared definitions for the PWM fade controller.
//   fade_state_e : FSM state encoding for pwm_fade_ctrl.
//   sat_sub      : saturating subtract. Returns 0 where a plain subtract
//                  would wrap below zero.
package pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } fade_state_e;

    // The operands are 32 bits wide so the helper works for any CTR_LEN.
    // It also keeps large channel offsets from aliasing before the compare.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer -- free-running PWM period counter and level-step tick.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset; sets the counter to 0 so it
//                 stays aligned with the PWM counter
//   step_tick_o : high for one clk on the last count (pcnt == max) of every
//                 STEP_PERIODS-th period
module pwm_step_timer #(
    parameter int CTR_LEN      = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic step_tick_o
);

    localparam int                 PW       = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [CTR_LEN-1:0] PCNT_MAX = '1;
    localparam logic [PW-1:0]      PER_LAST = PW'(STEP_PERIODS - 1);

    logic [CTR_LEN-1:0] pcnt_q;
    logic [PW-1:0]      per_q;
    logic               wrap;

    assign wrap = (pcnt_q == PCNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            per_q  <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
            if (wrap) per_q <= (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        end
    end

    // The tick sits on the final count of a period. Anything registered on
    // this tick therefore becomes visible from pcnt == 0 of the next period.
    assign step_tick_o = wrap && (per_q == PER_LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl -- multi-channel PWM compare generator. The shared level
// ramps up, holds, ramps down and holds again, repeating until told to stop.
// Channel i trails the shared level by i*CH_OFFSET, which forms a gradient.
//   clk        : clock
//   rst        : synchronous active-high reset
//   start      : one-cycle request to begin the loop (used only in IDLE)
//   stop       : one-cycle request to fade out gracefully to IDLE
//   compare    : registered per-channel compare values, channel i at
//                [i*CTR_LEN +: CTR_LEN]
//   level      : current shared level
//   busy       : state is not IDLE
//   cycle_done : one-clk pulse on each entry to HOLD_LO
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int CTR_LEN      = 8,
    parameter int NUM_CH       = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_STEPS   = 16,
    parameter int CH_OFFSET    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    output logic [NUM_CH*CTR_LEN-1:0] compare,
    output logic [CTR_LEN-1:0]        level,
    output logic                      busy,
    output logic                      cycle_done
);

    localparam int                 HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [CTR_LEN-1:0] LVL_MAX   = '1;
    localparam logic [CTR_LEN-1:0] LVL_ONE   = CTR_LEN'(1);

    fade_state_e                     state_q, state_d;
    logic [CTR_LEN-1:0]              level_q, level_d;
    logic [HW-1:0]                   hold_q, hold_d;
    logic                            stop_pend_q, stop_pend_d;
    logic                            busy_q, cdone_q, cdone_d;
    logic [NUM_CH-1:0][CTR_LEN-1:0]  compare_q, compare_d;
    logic                            step_tick;
    logic                            fade_out;

    pwm_step_timer #(
        .CTR_LEN      (CTR_LEN),
        .STEP_PERIODS (STEP_PERIODS)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .step_tick_o (step_tick)
    );

    // A stop that lands on the tick cycle itself takes effect on that tick.
    assign fade_out = stop_pend_q | stop;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        hold_d      = hold_q;
        cdone_d     = 1'b0;
        stop_pend_d = stop_pend_q | (stop && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                // A simultaneous start and stop leaves the controller idle.
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = ST_UP;
                    level_d = '0;
                    hold_d  = '0;
                end
            end
            ST_UP: if (step_tick) begin
                if (fade_out) begin
                    state_d = ST_DOWN;
                end else if (level_q >= LVL_MAX - 1'b1) begin
                    level_d = LVL_MAX;
                    state_d = ST_HOLD_HI;
                    hold_d  = '0;
                end else begin
                    level_d = level_q + 1'b1;
                end
            end
            ST_HOLD_HI: if (step_tick) begin
                if (fade_out || hold_q == HOLD_LAST) begin
                    state_d = ST_DOWN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DOWN: if (step_tick) begin
                // The <= 1 test also covers entering DOWN at level 0 (stop
                // raised early in UP), so the decrement cannot wrap.
                if (level_q <= LVL_ONE) begin
                    level_d = '0;
                    state_d = ST_HOLD_LO;
                    hold_d  = '0;
                    cdone_d = 1'b1;
                end else begin
                    level_d = level_q - 1'b1;
                end
            end
            ST_HOLD_LO: if (step_tick) begin
                if (fade_out) begin
                    state_d     = ST_IDLE;
                    stop_pend_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_UP;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare values come from the next level. They are registered on the
    // same edge as the level, so a new value starts exactly at pcnt == 0.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign compare_d[g] = CTR_LEN'(sat_sub(32'(level_d), 32'(g * CH_OFFSET)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            hold_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            cdone_q     <= 1'b0;
            compare_q   <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= (state_d != ST_IDLE);
            cdone_q     <= cdone_d;
            compare_q   <= compare_d;
        end
    end

    assign compare    = compare_q;
    assign level      = level_q;
    assign busy       = busy_q;
    assign cycle_done = cdone_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl -- scoreboard bench for pwm_fade_ctrl with CTR_LEN=3,
// NUM_CH=8, STEP_PERIODS=1, HOLD_STEPS=2 and CH_OFFSET=1, so a step tick
// occurs every 8 clk. The stimulus process queues each expected output change
// as a tuple {busy, level, compare, cycle_done, cycles since previous change}.
// The monitor pops one entry every time the outputs change and compares them.
module tb_pwm_fade_ctrl;

    localparam int CL = 3;
    localparam int NC = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [NC*CL-1:0] compare;
    logic [CL-1:0]    level;
    logic             busy;
    logic             cycle_done;

    pwm_fade_ctrl #(
        .CTR_LEN(3), .NUM_CH(8), .STEP_PERIODS(1), .HOLD_STEPS(2), .CH_OFFSET(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .compare(compare), .level(level), .busy(busy), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             busy;
        logic [CL-1:0]    lvl;
        logic [NC*CL-1:0] cmp;
        logic             cd;
        int               gap;   // -1: not checked
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk   = 0;
    int         n_err   = 0;
    int         cyc_abs = 0;
    logic [2:0] pc      = 3'd0;  // reference period counter (pcnt)
    bit         mon_en  = 1'b0;

    function automatic logic [NC*CL-1:0] ramp_cmp(input int l);
        logic [NC*CL-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++)
            r[i*CL +: CL] = (l > i) ? CL'(l - i) : '0;
        return r;
    endfunction

    task automatic push(input logic b, input int l, input logic c, input int g);
        exp_t e;
        e.busy = b;
        e.lvl  = CL'(l);
        e.cmp  = ramp_cmp(l);
        e.cd   = c;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step();
            k++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: pending events=%0d, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc_abs++;
            if (rst) pc = 3'd0;
            else     pc = pc + 3'd1;
        end
    end

    initial begin : monitor
        logic             p_busy, p_cd;
        logic [CL-1:0]    p_lvl;
        logic [NC*CL-1:0] p_cmp;
        int               last;
        exp_t             e;
        wait (mon_en);
        p_busy = 1'b0; p_cd = 1'b0; p_lvl = '0; p_cmp = '0;
        last = cyc_abs;
        forever begin
            @(negedge clk);
            if ({busy, level, compare, cycle_done} !== {p_busy, p_lvl, p_cmp, p_cd}) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: busy=%0d level=%0d compare=%h cycle_done=%0d, required no change",
                             busy, level, compare, cycle_done);
                end else begin
                    e = exp_q.pop_front();
                    if (busy !== e.busy || level !== e.lvl || compare !== e.cmp ||
                        cycle_done !== e.cd || (e.gap >= 0 && (cyc_abs - last) != e.gap)) begin
                        n_err++;
                        $display("FAIL event: got busy=%0d level=%0d compare=%h cd=%0d gap=%0d, required busy=%0d level=%0d compare=%h cd=%0d gap=%0d",
                                 busy, level, compare, cycle_done, cyc_abs - last,
                                 e.busy, e.lvl, e.cmp, e.cd, e.gap);
                    end
                end
                if (level !== p_lvl || compare !== p_cmp) begin
                    n_chk++;
                    if (pc != 3'd0) begin
                        n_err++;
                        $display("FAIL phase: level/compare changed at pcnt=%0d, required 0", pc);
                    end
                end
                if (level == 3'd5) begin
                    n_chk++;
                    if (compare !== 24'h0014E5) begin
                        n_err++;
                        $display("FAIL level5_compare: got %h, required 0014e5", compare);
                    end
                end
                p_busy = busy; p_lvl = level; p_cmp = compare; p_cd = cycle_done;
                last = cyc_abs;
            end
        end
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state, then 100 idle clocks with no output movement.
        n_chk++;
        if ({busy, level, compare, cycle_done} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%0d level=%0d compare=%h cd=%0d, required all 0",
                     busy, level, compare, cycle_done);
        end
        repeat (100) step();
        n_chk++;
        if ({busy, level, compare, cycle_done} !== '0) begin
            n_err++;
            $display("FAIL idle_state: got busy=%0d level=%0d compare=%h cd=%0d, required all 0",
                     busy, level, compare, cycle_done);
        end

        // Full loop: ramp up, hold high, ramp down, hold low, then UP again to 3.
        push(1, 0, 0, -1);
        push(1, 1, 0, -1);
        for (int l = 2; l <= 7; l++) push(1, l, 0, 8);
        push(1, 6, 0, 24);
        for (int l = 5; l >= 1; l--) push(1, l, 0, 8);
        push(1, 0, 1, 8);
        push(1, 0, 0, 1);
        push(1, 1, 0, 23);
        push(1, 2, 0, 8);
        push(1, 3, 0, 8);
        start = 1'b1; step(); start = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %0d, required 1", busy);
        end
        drain(400, "full_loop");

        // Stop at level 3: fade to 0, one HOLD_LO tick, then IDLE. The
        // start pulse during the fade must not change anything.
        push(1, 2, 0, 16);
        push(1, 1, 0, 8);
        push(1, 0, 1, 8);
        push(1, 0, 0, 1);
        push(0, 0, 0, 7);
        stop = 1'b1; step(); stop = 1'b0;
        repeat (12) step();
        start = 1'b1; step(); start = 1'b0;
        drain(200, "stop_fade");

        // Simultaneous start+stop in IDLE, then a lone stop: both ignored.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        repeat (30) step();
        n_chk++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_stop_idle: busy=%0d, required 0", busy);
        end
        stop = 1'b1; step(); stop = 1'b0;
        repeat (5) step();

        // Restart and run into DOWN down to level 4.
        push(1, 0, 0, -1);
        push(1, 1, 0, -1);
        for (int l = 2; l <= 7; l++) push(1, l, 0, 8);
        push(1, 6, 0, 24);
        push(1, 5, 0, 8);
        push(1, 4, 0, 8);
        start = 1'b1; step(); start = 1'b0;
        drain(400, "second_ramp");

        // Reset mid-DOWN at level 4, then start on the first clk after reset.
        push(0, 0, 0, 1);
        push(1, 0, 0, 1);
        push(1, 1, 0, 7);
        push(1, 2, 0, 8);
        rst = 1'b1; step();
        rst = 1'b0; start = 1'b1; step(); start = 1'b0;
        drain(100, "reset_restart");

        repeat (4) step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: pending events=%0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
